// File: rtl/montgomery_mult.sv
`timescale 1ns/1ps
// Bit-serial radix-2 Montgomery multiplier: result = in_a * in_b * 2^-WIDTH mod in_m.
// Every addition and the final conditional subtraction go through an external adder handshake.
module montgomery_mult #(
  parameter int WIDTH = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             add_start,
  output logic             add_subtract,
  output logic [WIDTH+2:0] add_in_a,
  output logic [WIDTH+2:0] add_in_b,
  input  logic [WIDTH+3:0] add_result,
  input  logic             add_done
);

  localparam int CW = WIDTH + 3;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_BIT = IW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TEST_A,
    S_WAIT_B,
    S_TEST_C,
    S_WAIT_M,
    S_SHIFT,
    S_SUB,
    S_WAIT_S
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_ADD_B,
    OP_ADD_M,
    OP_SUB_M
  } op_t;

  state_t r_state;
  state_t w_state_next;
  op_t    w_op;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_result;
  logic [CW-1:0]    r_c;
  logic [IW-1:0]    r_i;
  logic             r_done;
  logic             r_add_start;
  logic             r_add_subtract;
  logic [CW-1:0]    r_add_in_a;
  logic [CW-1:0]    r_add_in_b;

  logic             w_last;
  logic [WIDTH-1:0] w_operand;

  assign w_last    = (r_i == LAST_BIT);
  assign w_operand = (w_op == OP_ADD_B) ? r_b : r_m;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A bit with nothing to add skips TEST_C so an all-zero bit costs two cycles.
  always_comb begin
    w_state_next = r_state;
    w_op         = OP_NONE;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_TEST_A;
        end
      end
      S_TEST_A: begin
        if (r_a[0]) begin
          w_op         = OP_ADD_B;
          w_state_next = S_WAIT_B;
        end else if (r_c[0]) begin
          w_state_next = S_TEST_C;
        end else begin
          w_state_next = S_SHIFT;
        end
      end
      S_WAIT_B: begin
        if (add_done) begin
          w_state_next = S_TEST_C;
        end
      end
      S_TEST_C: begin
        if (r_c[0]) begin
          w_op         = OP_ADD_M;
          w_state_next = S_WAIT_M;
        end else begin
          w_state_next = S_SHIFT;
        end
      end
      S_WAIT_M: begin
        if (add_done) begin
          w_state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_state_next = w_last ? S_SUB : S_TEST_A;
      end
      S_SUB: begin
        w_op         = OP_SUB_M;
        w_state_next = S_WAIT_S;
      end
      S_WAIT_S: begin
        if (add_done) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // A is consumed LSB-first by shifting, so A[i] is always r_a[0].
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a <= '0;
      r_b <= '0;
      r_m <= '0;
      r_c <= '0;
      r_i <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a <= in_a;
            r_b <= in_b;
            r_m <= in_m;
            r_c <= '0;
            r_i <= '0;
          end
        end
        S_WAIT_B, S_WAIT_M: begin
          if (add_done) begin
            r_c <= add_result[CW-1:0];
          end
        end
        S_SHIFT: begin
          r_c <= r_c >> 1;
          r_a <= r_a >> 1;
          if (!w_last) begin
            r_i <= r_i + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Adder operands are only reloaded on issue, so they hold through each wait.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_add_start    <= 1'b0;
      r_add_subtract <= 1'b0;
      r_add_in_a     <= '0;
      r_add_in_b     <= '0;
    end else begin
      r_add_start <= 1'b0;
      if (w_op != OP_NONE) begin
        r_add_start    <= 1'b1;
        r_add_subtract <= (w_op == OP_SUB_M);
        r_add_in_a     <= r_c;
        r_add_in_b     <= {3'b000, w_operand};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      if ((r_state == S_WAIT_S) && add_done) begin
        r_done   <= 1'b1;
        r_result <= add_result[CW] ? r_c[WIDTH-1:0] : add_result[WIDTH-1:0];
      end
    end
  end

  assign result       = r_result;
  assign done         = r_done;
  assign add_start    = r_add_start;
  assign add_subtract = r_add_subtract;
  assign add_in_a     = r_add_in_a;
  assign add_in_b     = r_add_in_b;

endmodule

// File: tb/tb_montgomery_mult.sv
`timescale 1ns/1ps
// Bench for montgomery_mult: behavioural adder with fixed latency L and a
// Montgomery reference computed from the full product followed by modular halving.
module tb_montgomery_mult;

  localparam int W      = 1024;
  localparam int L      = 3;
  localparam int BUDGET = 4*W + 2*W*L + L + 64;

  logic           clk     = 1'b0;
  logic           reset   = 1'b0;
  logic           start   = 1'b0;
  logic [W-1:0]   in_a    = '0;
  logic [W-1:0]   in_b    = '0;
  logic [W-1:0]   in_m    = '0;
  logic [W-1:0]   result;
  logic           done;
  logic           add_start;
  logic           add_subtract;
  logic [W+2:0]   add_in_a;
  logic [W+2:0]   add_in_b;
  logic [W+3:0]   add_result = '0;
  logic           add_done   = 1'b0;

  int total = 0;
  int bad   = 0;
  int n_add = 0;
  int n_sub = 0;
  int txn   = 0;
  int lat;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] prev;
  logic [W-1:0] mfull;
  logic [W-1:0] bm2;

  montgomery_mult #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_m         (in_m),
    .result       (result),
    .done         (done),
    .add_start    (add_start),
    .add_subtract (add_subtract),
    .add_in_a     (add_in_a),
    .add_in_b     (add_in_b),
    .add_result   (add_result),
    .add_done     (add_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W+3:0] act, input logic [W+3:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (low 160 bits)", name, act[159:0], req[159:0]);
    end
  endtask

  // a*b*2^-W mod m: reduce the full product, then halve modulo m W times.
  function automatic logic [W-1:0] mont_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [W-1:0] m);
    logic [2*W-1:0] pa, pb, pm, pr;
    logic [W:0]     r;
    pa = {{W{1'b0}}, a};
    pb = {{W{1'b0}}, b};
    pm = {{W{1'b0}}, m};
    pr = (pa * pb) % pm;
    r  = pr[W:0];
    for (int k = 0; k < W; k++) begin
      r = r[0] ? ((r + {1'b0, m}) >> 1) : (r >> 1);
    end
    return r[W-1:0];
  endfunction

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] r;
    for (int k = 0; k < W/32; k++) begin
      r[k*32 +: 32] = $urandom;
    end
    return r;
  endfunction

  // Adder: sees add_start in the first wait cycle, answers in the L-th.
  initial begin
    logic [W+2:0] ca, cb;
    logic         cs;
    bit           aborted;
    forever begin
      @(negedge clk);
      if (add_start && !reset) begin
        n_add++;
        if (add_subtract) n_sub++;
        ca = add_in_a;
        cb = add_in_b;
        cs = add_subtract;
        chk("adder_top_bits_zero", {ca[W+2], cb[W+2]}, 0);
        aborted = 0;
        for (int k = 1; k < L; k++) begin
          @(negedge clk);
          if (reset) begin
            aborted = 1;
            break;
          end
          if (k == 1) chk("add_start_one_cycle", add_start, 0);
          chk("add_in_a_stable", add_in_a, ca);
          chk("add_in_b_stable", add_in_b, cb);
          chk("add_subtract_stable", add_subtract, cs);
        end
        if (!aborted) begin
          add_result = cs ? ({1'b0, ca} - {1'b0, cb}) : ({1'b0, ca} + {1'b0, cb});
          add_done   = 1'b1;
          @(negedge clk);
          add_done   = 1'b0;
          add_result = {rand_w(), 4'h0};
        end
      end
    end
  end

  // Output checker: result must match the queued expectation on done and hold otherwise.
  initial begin
    logic [W-1:0] e;
    prev = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = '0;
      end else if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", done, 0);
        end else begin
          e = exp_q.pop_front();
          chk("result", result, e);
        end
        prev = result;
      end else begin
        chk("result_hold", result, prev);
      end
    end
  end

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] m,
                        input logic [W-1:0] e, input int gap, output int latency);
    repeat (gap + 2) @(negedge clk);
    in_a  = a;
    in_b  = b;
    in_m  = m;
    start = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
    latency = 0;
    forever begin
      @(posedge clk);
      latency++;
      #1;
      if (done) break;
      if (latency > BUDGET) begin
        chk("done_timeout", done, 1);
        break;
      end
    end
    txn++;
    $display("txn %0d: m_lo=%08h result_lo=%08h expected_lo=%08h latency=%0d",
             txn, m[31:0], result[31:0], e[31:0], latency);
  endtask

  initial begin
    #(3_000_000);
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mfull = '1;
    bm2   = mfull - W'(1);

    #2 reset = 1'b1;
    #1;
    chk("rst_result", result, 0);
    chk("rst_done", done, 0);
    chk("rst_add_start", add_start, 0);
    chk("rst_add_subtract", add_subtract, 0);
    chk("rst_add_in_a", add_in_a, 0);
    chk("rst_add_in_b", add_in_b, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk("model_1_1_13", mont_ref(W'(1), W'(1), W'(13)), 9);
    chk("model_3_5_13", mont_ref(W'(3), W'(5), W'(13)), 5);
    chk("model_12_12_13", mont_ref(W'(12), W'(12), W'(13)), 9);
    chk("model_full_width", mont_ref(W'(1), bm2, mfull), {4'h0, bm2});

    run_op(W'(1), W'(1), W'(13), W'(9), 0, lat);
    repeat (5) @(negedge clk);
    chk("result_stays_9", result, 9);

    run_op(W'(3), W'(5), W'(13), W'(5), 0, lat);
    run_op(W'(12), W'(12), W'(13), W'(9), 0, lat);

    n_add = 0;
    n_sub = 0;
    run_op(W'(0), W'(7), W'(13), W'(0), 1, lat);
    chk("a0_latency", lat, 2*W + L + 1);
    chk("a0_add_count", n_add, 1);
    chk("a0_sub_count", n_sub, 1);

    run_op(W'(1), bm2, mfull, bm2, 1, lat);

    fork
      run_op(W'(3), W'(5), W'(13), W'(5), 0, lat);
      begin : stray
        bit seen;
        seen = 0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 40 && !seen; k++) begin
          @(negedge clk);
          if (add_start) seen = 1;
        end
        chk("stray_add_start_seen", seen, 1);
        if (seen) begin
          chk("stray_first_is_add", add_subtract, 0);
          start = 1'b1;
          in_a  = W'(1);
          in_b  = W'(1);
          @(negedge clk);
          start = 1'b0;
        end
      end
    join

    repeat (2) @(negedge clk);
    in_a  = rand_w() & ~(W'(1) << (W-1));
    in_b  = W'(12345);
    in_m  = mfull;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100 + $urandom_range(0, 20)) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_result", result, 0);
    chk("midrst_done", done, 0);
    chk("midrst_add_start", add_start, 0);
    chk("midrst_add_subtract", add_subtract, 0);
    chk("midrst_add_in_a", add_in_a, 0);
    chk("midrst_add_in_b", add_in_b, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    run_op(W'(1), W'(1), W'(13), W'(9), 0, lat);

    for (int t = 0; t < 4; t++) begin
      int           nb;
      logic [W-1:0] m, a, b, e;
      nb = (t == 0) ? W : $urandom_range(2, W-1);
      m  = rand_w() >> (W - nb);
      m[0]    = 1'b1;
      m[nb-1] = 1'b1;
      a  = rand_w() % m;
      b  = rand_w() % m;
      e  = mont_ref(a, b, m);
      run_op(a, b, m, e, $urandom_range(0, 3), lat);
    end

    repeat (3) @(negedge clk);
    chk("no_pending_results", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
